// File: rtl/pipeline_stall_control_if.sv
// Stall request / stall vector bundle between the pipeline stages and the
// central stall generator.
interface pipeline_stall_control_if #(
  parameter int COUNT_WIDTH = 6
);
  logic                   id_stall_request;
  logic                   ex_stall_request;
  logic                   ex_multicycle_start;
  logic [COUNT_WIDTH-1:0] ex_multicycle_cycles;
  logic                   mem_stall_request;
  logic                   flush;
  logic [5:0]             stall;
  logic                   ex_multicycle_busy;
  logic                   ex_multicycle_done;
  logic [31:0]            stall_cycles;

  // master: the pipeline stages raising requests and consuming the stall vector
  modport master (
    output id_stall_request, ex_stall_request, ex_multicycle_start,
           ex_multicycle_cycles, mem_stall_request, flush,
    input  stall, ex_multicycle_busy, ex_multicycle_done, stall_cycles
  );

  // slave: the stall generator itself
  modport slave (
    input  id_stall_request, ex_stall_request, ex_multicycle_start,
           ex_multicycle_cycles, mem_stall_request, flush,
    output stall, ex_multicycle_busy, ex_multicycle_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_control.sv
// Central stall generator: priority-encodes ID/EX/MEM stall requests into the
// per-stage hold vector, sequences multi-cycle EX ops and counts stall cycles.
module pipeline_stall_control #(
  parameter int COUNT_WIDTH = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  pipeline_stall_control_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [31:0]            stall_cycles_q;

  logic                   short_op;
  logic [COUNT_WIDTH-1:0] load_value;
  logic                   start_ok;
  logic                   ex_hold;
  logic                   done;
  logic [5:0]             stall;

  // N of 0 or 1 completes in the start cycle itself; otherwise N-1 more cycles follow.
  assign short_op   = (bus.ex_multicycle_cycles <= COUNT_WIDTH'(1));
  assign load_value = short_op ? '0 : bus.ex_multicycle_cycles - COUNT_WIDTH'(1);
  assign start_ok   = (state_q == IDLE) && bus.ex_multicycle_start && !bus.flush;

  assign ex_hold = bus.ex_stall_request
                || (state_q == BUSY)
                || ((state_q == IDLE) && bus.ex_multicycle_start);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    stall = 6'b000000;
    if (reset || bus.flush)         stall = 6'b000000;
    else if (bus.mem_stall_request) stall = 6'b011111;
    else if (ex_hold)               stall = 6'b001111;
    else if (bus.id_stall_request)  stall = 6'b000111;
  end

  // Done is suppressed whenever MEM holds the pipe or the op is being flushed.
  assign done = !reset && !bus.mem_stall_request && !bus.flush
             && (((state_q == BUSY) && (count_q == COUNT_WIDTH'(1)))
              || (start_ok && short_op));

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (stall[0]) stall_cycles_q <= stall_cycles_q + 32'd1;

      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            count_q <= load_value;
            if (!short_op) state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (!bus.mem_stall_request) begin
            count_q <= count_q - COUNT_WIDTH'(1);
            if (count_q == COUNT_WIDTH'(1)) state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.stall              = stall;
  assign bus.ex_multicycle_busy = (state_q == BUSY);
  assign bus.ex_multicycle_done = done;
  assign bus.stall_cycles       = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Self-checking bench for pipeline_stall_control: directed scenarios with
// constant expectations plus a randomized run against an owed-cycles model.
module tb_pipeline_stall_control;

  localparam int CW = 6;

  logic clock;
  logic reset;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  pipeline_stall_control_if #(.COUNT_WIDTH(CW)) bus ();

  pipeline_stall_control #(.COUNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: an op owes max(N,1) non-MEM cycles, the start cycle always paying one.
  bit          m_in_op;
  int          m_owed;
  logic [31:0] m_count;

  function automatic logic [5:0] m_stall();
    if (reset || bus.flush)                                      return 6'b000000;
    if (bus.mem_stall_request)                                   return 6'b011111;
    if (bus.ex_stall_request || m_in_op || bus.ex_multicycle_start) return 6'b001111;
    if (bus.id_stall_request)                                    return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic int n_eff();
    return (bus.ex_multicycle_cycles == 0) ? 1 : int'(bus.ex_multicycle_cycles);
  endfunction

  function automatic bit m_done();
    if (reset || bus.mem_stall_request || bus.flush) return 1'b0;
    if (m_in_op) return (m_owed == 1);
    return bus.ex_multicycle_start && (n_eff() == 1);
  endfunction

  task automatic m_advance();
    logic [5:0] s;
    s = m_stall();
    if (s[0]) m_count = m_count + 32'd1;
    if (bus.flush) begin
      m_in_op = 1'b0;
      m_owed  = 0;
    end else if (m_in_op) begin
      if (!bus.mem_stall_request) begin
        m_owed = m_owed - 1;
        if (m_owed == 0) m_in_op = 1'b0;
      end
    end else if (bus.ex_multicycle_start) begin
      m_owed  = n_eff() - 1;
      m_in_op = (m_owed > 0);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled 3 units before the rising edge.
  task automatic drive(input bit id, input bit ex, input bit st, input int n,
                       input bit mem, input bit fl);
    @(negedge clock);
    bus.id_stall_request     = id;
    bus.ex_stall_request     = ex;
    bus.ex_multicycle_start  = st;
    bus.ex_multicycle_cycles = CW'(n);
    bus.mem_stall_request    = mem;
    bus.flush                = fl;
    #2;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    bus.id_stall_request = 0; bus.ex_stall_request = 0; bus.ex_multicycle_start = 0;
    bus.ex_multicycle_cycles = '0; bus.mem_stall_request = 0; bus.flush = 0;
    @(negedge clock);
    reset   = 1'b0;
    m_in_op = 1'b0;
    m_owed  = 0;
    m_count = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 5, 1, 0);
      n_compared++;
      if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, bus.stall_cycles} !== 40'd0) begin
        n_mismatched++;
        $display("FAIL reset_hold %0d: stall=%b busy=%b done=%b cnt=%0d, want all zero",
                 i, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, bus.stall_cycles);
      end
    end
  endtask

  task automatic test_priorities();
    logic [5:0] want [4] = '{6'b000111, 6'b001111, 6'b011111, 6'b000000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i >= 1, 0, 0, i >= 2, i >= 3);
      n_compared++;
      if (bus.stall !== want[i]) begin
        n_mismatched++;
        $display("FAIL priority step %0d: stall=%b, want %b", i, bus.stall, want[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [5:0] es;
    bit eb, ed;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      drive(0, 0, c == 1, 5, 0, 0);
      es = (c <= 5) ? 6'b001111 : 6'b000000;
      eb = (c >= 2 && c <= 5);
      ed = (c == 5);
      n_compared++;
      if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done} !== {es, eb, ed}) begin
        n_mismatched++;
        $display("FAIL divide cycle %0d: stall=%b busy=%b done=%b, want stall=%b busy=%b done=%b",
                 c, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, es, eb, ed);
      end
    end
    n_compared++;
    if (bus.stall_cycles !== 32'd5) begin
      n_mismatched++;
      $display("FAIL divide stall_cycles: got %0d, want 5", bus.stall_cycles);
    end
  endtask

  task automatic test_degenerate();
    for (int n = 0; n <= 1; n++) begin
      do_reset();
      for (int c = 1; c <= 2; c++) begin
        drive(0, 0, c == 1, n, 0, 0);
        n_compared++;
        if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done}
            !== {(c == 1) ? 6'b001111 : 6'b000000, 1'b0, c == 1}) begin
          n_mismatched++;
          $display("FAIL degenerate N=%0d cycle %0d: stall=%b busy=%b done=%b, want stall=%b busy=0 done=%b",
                   n, c, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done,
                   (c == 1) ? 6'b001111 : 6'b000000, c == 1);
        end
      end
    end
  endtask

  task automatic test_mem_during_busy();
    logic [5:0] es;
    bit eb, ed, mem;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      mem = (c == 2 || c == 3);
      drive(0, 0, c == 1, 4, mem, 0);
      es = mem ? 6'b011111 : ((c <= 6) ? 6'b001111 : 6'b000000);
      eb = (c >= 2 && c <= 6);
      ed = (c == 6);
      n_compared++;
      if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done} !== {es, eb, ed}) begin
        n_mismatched++;
        $display("FAIL mem_busy cycle %0d: stall=%b busy=%b done=%b, want stall=%b busy=%b done=%b",
                 c, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, es, eb, ed);
      end
    end
  endtask

  task automatic test_flush_abort();
    logic [5:0] es;
    bit eb;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      drive(0, 0, c == 1, 10, 0, c == 3);
      es = (c <= 2) ? 6'b001111 : 6'b000000;
      eb = (c == 2 || c == 3);
      n_compared++;
      if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done} !== {es, eb, 1'b0}) begin
        n_mismatched++;
        $display("FAIL flush cycle %0d: stall=%b busy=%b done=%b, want stall=%b busy=%b done=0",
                 c, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, es, eb);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    drive(0, 0, 1, 10, 0, 0);
    drive(0, 0, 0, 10, 0, 0);
    drive(0, 0, 0, 10, 0, 0);
    drive(0, 0, 0, 10, 0, 0);
    n_compared++;
    if ({bus.ex_multicycle_busy, bus.stall_cycles} !== {1'b1, 32'd3}) begin
      n_mismatched++;
      $display("FAIL pre_reset: busy=%b cnt=%0d, want busy=1 cnt=3", bus.ex_multicycle_busy, bus.stall_cycles);
    end
    #1 reset = 1'b1;
    #1;
    n_compared++;
    if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, bus.stall_cycles} !== 40'd0) begin
      n_mismatched++;
      $display("FAIL async_reset: stall=%b busy=%b done=%b cnt=%0d, want all zero",
               bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, bus.stall_cycles);
    end
    @(negedge clock) reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_compared++;
      if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done} !== 8'd0) begin
        n_mismatched++;
        $display("FAIL post_reset cycle %0d: stall=%b busy=%b done=%b, want all zero",
                 c, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done);
      end
    end
  endtask

  task automatic test_counter();
    do_reset();
    for (int c = 0; c < 7; c++) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_compared++;
    if (bus.stall_cycles !== 32'd7) begin
      n_mismatched++;
      $display("FAIL counter: stall_cycles=%0d, want 7", bus.stall_cycles);
    end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    do_reset();
    @(negedge clock);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 0, 0, c == 2);
      n_compared++;
      if (bus.stall_cycles !== want[c]) begin
        n_mismatched++;
        $display("FAIL counter_wrap step %0d: stall_cycles=%h, want %h", c, bus.stall_cycles, want[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] es;
    bit ed;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3,
            $urandom_range(0, 9) < 2, $urandom_range(0, 12),
            $urandom_range(0, 9) < 2, $urandom_range(0, 24) < 2);
      es = m_stall();
      ed = m_done();
      n_compared++;
      if ({bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, bus.stall_cycles}
          !== {es, m_in_op, ed, m_count}) begin
        n_mismatched++;
        $display("FAIL random cycle %0d: stall=%b busy=%b done=%b cnt=%0d, want stall=%b busy=%b done=%b cnt=%0d",
                 c, bus.stall, bus.ex_multicycle_busy, bus.ex_multicycle_done, bus.stall_cycles,
                 es, m_in_op, ed, m_count);
      end
      m_advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.id_stall_request = 0; bus.ex_stall_request = 0; bus.ex_multicycle_start = 0;
    bus.ex_multicycle_cycles = '0; bus.mem_stall_request = 0; bus.flush = 0;
    m_in_op = 1'b0; m_owed = 0; m_count = '0;

    test_reset();
    test_priorities();
    test_divide();
    test_degenerate();
    test_mem_during_busy();
    test_flush_abort();
    test_reset_abort();
    test_counter();
    test_counter_wrap();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
